fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter MEMORY_SIZE, default 2048, number of 32-bit instruction words.
REQ-002 Parameter MEMORY_BITS, default 11, instruction-memory address width.
REQ-003 Parameter DEPTH, default 4, fetch-buffer entries (power of two, >=2).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 redirect_valid  in  1  load new fetch PC and flush (branch/jump resolve).
REQ-007 redirect_pc  in  32  new fetch word address.
REQ-008 mem_addr  out  MEMORY_BITS  address to synchronous instruction ROM.
REQ-009 mem_req  out  1  address issued this cycle.
REQ-010 mem_rdata  in  32  ROM output, valid the cycle after mem_req.
REQ-011 out_valid  out  1  buffered instruction available.
REQ-012 out_ready  in  1  consumer (decode/InstQ stage) accepts the head entry.
REQ-013 out_inst  out  32  head instruction word.
REQ-014 out_pc  out  32  word address of head instruction.
REQ-015 halted  out  1  fetch stopped at an out-of-range PC.

Function
REQ-016 States: RUN, HALT; transfer on out_valid && out_ready.
REQ-017 mem_addr = fetch_pc[MEMORY_BITS-1:0], combinational.
REQ-018 In RUN, mem_req = 1 iff !redirect_valid && (count + inflight) < DEPTH && fetch_pc <= MEMORY_SIZE-1.
REQ-019 On mem_req, fetch_pc increments by 1 and inflight (1 bit) sets with the issued PC recorded.
REQ-020 One cycle after mem_req, when inflight is set and not squashed, mem_rdata and recorded PC are written at the buffer tail.
REQ-021 Credit rule: a response always has a free slot; the buffer never overflows.
REQ-022 In the same cycle, a dequeue and an enqueue are both performed and count is unchanged.
REQ-023 out_valid = (count != 0) && !redirect_valid; out_inst/out_pc show the head entry.
REQ-024 Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 redirect_valid: count <= 0, pointers <= 0, in-flight response discarded, fetch_pc <= redirect_pc, no mem_req that cycle, and state <= RUN.
REQ-026 A redirect overrides a simultaneous out_ready; no transfer occurs in that cycle.
REQ-027 When RUN and fetch_pc > MEMORY_SIZE-1 (unsigned), state <= HALT; outstanding response and buffered entries still drain.
REQ-028 In HALT: mem_req = 0 and halted = 1; leaves HALT only on redirect.
REQ-029 A redirect to an out-of-range PC enters RUN, then HALT the next cycle, with no mem_req.
REQ-030 Buffer full (count == DEPTH) with out_ready = 0: the outputs hold stable.

Reset
REQ-031 While rst = 0: fetch_pc = 0, count = 0, pointers = 0, inflight = 0, and state = RUN.
REQ-032 While rst = 0: out_valid = 0, mem_req = 0, halted = 0, out_inst = 0, and out_pc = 0.
REQ-033 Reset mid-operation discards all buffered and in-flight data.
REQ-034 The first mem_req, to address 0, occurs in the first cycle after reset release.

Structure
REQ-035 A shared package holds MEMORY_SIZE/MEMORY_BITS defaults and the RUN/HALT state encoding.
REQ-036 A sub-module fetch_fifo (DEPTH x 64-bit, count/ptr logic) holds the buffer; the parent holds PC, inflight, credit, and FSM.

Verification
REQ-037 Reset release, out_ready=1, ROM[i]=i+100 -> out_pc 0,1,2,... each with out_inst i+100, one per cycle after 2-cycle startup latency.
REQ-038 out_ready=0 for 10 cycles -> exactly DEPTH (4) mem_req pulses, count=4; the head stays pc 0; release -> pcs 0..n delivered in order with no loss or duplicate.
REQ-039 Redirect to 0x40 while 3 entries are buffered and 1 is in flight -> out_valid=0 that cycle; the next delivered out_pc is 0x40, and no stale entry appears.
REQ-040 Fetch runs to PC 2047 -> pc 2047 is delivered, halted=1, and no mem_req follows; redirect to 5 -> halted=0 and pc 5 is delivered.
REQ-041 rst asserted while count=2 and inflight=1 -> all outputs are 0 immediately (async); after release, delivery restarts from pc 0.
REQ-042 Redirect_valid and out_ready asserted together with count=1 -> no transfer counted, and the buffer is empty the next cycle.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared defaults and types for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned MEMORY_SIZE_DEF = 2048;
  localparam int unsigned MEMORY_BITS_DEF = 11;
  localparam int unsigned DEPTH_DEF       = 4;

  // Fetch control state: RUN issues requests, HALT waits for a redirect.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Buffer entry layout: instruction word above its word address.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {inst, pc}, wrapping head/tail pointers.
module fetch_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  output logic [63:0]              head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // Storage is cleared on reset so the head reads zero until first fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + PTR_ONE;
      end
      if (pop) head_ptr <= head_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  assign head_data = mem[head_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC generation, credit-limited ROM requests,
// single in-flight response tracking and a small decoupling buffer.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int MEMORY_SIZE = MEMORY_SIZE_DEF,
  parameter int MEMORY_BITS = MEMORY_BITS_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [MEMORY_BITS-1:0] mem_addr,
  output logic                   mem_req,
  input  logic [31:0]            mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic                   halted
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0]   LAST_PC = 32'(MEMORY_SIZE - 1);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW:0]   count;
  logic [PW+1:0] occupancy;
  logic [63:0]   head_data;
  logic          in_range;
  logic          issue;
  logic          enq;
  logic          deq;

  assign in_range  = (fetch_pc <= LAST_PC);
  // Buffered plus in-flight entries; a request is only issued with a free slot
  // reserved, so every response is guaranteed space at the tail.
  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign issue     = rst && (state == RUN) && !redirect_valid &&
                     (occupancy < DEPTH_W) && in_range;

  assign mem_req   = issue;
  assign mem_addr  = fetch_pc[MEMORY_BITS-1:0];

  assign out_valid = (count != '0) && !redirect_valid;
  assign deq       = out_valid && out_ready;
  assign enq       = inflight && !redirect_valid;

  assign out_inst  = head_data[63:32];
  assign out_pc    = head_data[31:0];

  // Fetch FSM: PC, in-flight tracking, halt on out-of-range PC, redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      halted      <= 1'b0;
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      state    <= RUN;
      halted   <= 1'b0;
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd1;
        inflight_pc <= fetch_pc;
      end
      if (state == RUN && !in_range) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (enq),
    .push_data ({mem_rdata, inflight_pc}),
    .pop       (deq),
    .head_data (head_data),
    .count     (count)
  );

endmodule
